buffer_pkt_arbiter: RTL and testbench
=====================================

# buffer_pkt_arbiter

Packet-level scheduler in front of `buffer_FIFO` in the softmax accelerator. It shares the single collect/drain buffer between two upstream requesters using round-robin. Each granted packet is held until its last beat is accepted, and the buffer must fully drain before the next grant is issued. Packets longer than `DEPTH` are truncated and their excess beats dropped. The owner channel is tagged for the drain side.

## Interface
- `DEPTH`, 64: buffer capacity in words; must match the attached `buffer_FIFO`.
- `LEN_W`, `$clog2(DEPTH+1)`: width of length counters.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `s0_valid_i` in 1: requester 0 beat valid.
- `s0_data_i` in 32: requester 0 data.
- `s0_last_i` in 1: requester 0 end of packet.
- `s0_ready_o` out 1: requester 0 beat accepted.
- `s1_valid_i`, `s1_data_i`, `s1_last_i`, `s1_ready_o`: same as requester 0, for requester 1.
- `b_valid_o` out 1: beat to buffer `s_valid_i`.
- `b_data_o` out 32: beat to buffer `s_data_i`.
- `b_last_o` out 1: beat to buffer `s_last_i`.
- `b_ready_i` in 1: from buffer `s_ready_o`.
- `b_drain_i` in 1: buffer `m_valid_o`, one pulse per drained word.
- `m_chan_o` out 1: owner of the packet currently buffered/draining.
- `pkt_len_o` out LEN_W: words stored for the current packet.
- `busy_o` out 1: state != IDLE.
- `ovf_o` out 1: one-cycle pulse on truncation.

## Operation
- State IDLE (reset):
  - If any `sN_valid_i` is high, grant one requester.
  - With both valid, grant the requester not granted last. `last_grant` resets to 1, so ch0 wins the first tie.
  - Store the grant in `m_chan_o`, clear `fill_cnt` and `drain_cnt`, go to FILL.
- State FILL:
  - Data path, combinational: `b_valid_o = sG_valid_i`, `b_data_o = sG_data_i`.
  - `b_last_o = sG_last_i | (fill_cnt == DEPTH-1)`.
  - `sG_ready_o = b_ready_i`.
  - On each handshake, `fill_cnt++`.
  - Handshake with `sG_last_i` high: `pkt_len_o = fill_cnt+1`, go to DRAIN.
  - Handshake at `fill_cnt == DEPTH-1` with `sG_last_i` low: `pkt_len_o = DEPTH`, pulse `ovf_o`, go to DROP.
- State DROP:
  - `sG_ready_o = 1`, `b_valid_o = 0`; beats are discarded.
  - On handshake with `sG_last_i` high: go to IDLE if `drain_cnt` (including this cycle's pulse) equals `pkt_len_o`, else go to DRAIN.
- State DRAIN:
  - All ready outputs are 0.
  - When `drain_cnt` (including this cycle's pulse) equals `pkt_len_o`, go to IDLE.
- Drain counting:
  - `drain_cnt` increments on `b_drain_i` in DROP and DRAIN only.
  - `b_drain_i` in IDLE or FILL is ignored.
- The non-granted requester always sees `ready = 0`. Outputs toward the buffer are 0 outside FILL.
- `last_grant` updates on the grant cycle.

## Timing
- Reset values:
  - `s0_ready_o`, `s1_ready_o`, `b_valid_o`, `b_last_o`, `busy_o`, `ovf_o`, `m_chan_o` = 0.
  - `b_data_o` = 0.
  - `pkt_len_o` = 0.
  - State = IDLE.
- Reset mid-packet: everything returns to reset values immediately. The buffer shares `rst_n`, so there is no partial-packet recovery.
- Arbitration latency: valid seen in IDLE at cycle t allows the first handshake at t+1 at the earliest.
- Length-1 packet: FILL lasts 1 cycle, then DRAIN.
- Turnaround: the final drain pulse at cycle t gives IDLE at t+1, and the next packet's first beat at t+2.
- A requester dropping valid mid-packet stalls FILL; the grant is never revoked.
- `ovf_o` is registered; it is high in the first DROP cycle.

## Structure
- Shared package `softmax_buf_pkg`:
  - State enum: IDLE/FILL/DROP/DRAIN.
  - Default `DEPTH` = 64.
  - Data width constant = 32.
- One natural sub-module, `rr2_picker`: a combinational 2-way round-robin pick from two valids plus `last_grant`.
- The FSM, counters and muxes stay in `buffer_pkt_arbiter`.

## Test plan
- Only ch0 sends 3 words A,B,C with last on C; bench drains with `m_ready` high. Expect buffer output A,B,C, `m_chan_o = 0`, `pkt_len_o = 3`, IDLE 1 cycle after the third drain pulse.
- Both channels are valid continuously with 2-word packets. Expect grant order ch0, ch1, ch0, ch1, and `s1_ready_o` never high while ch0 is granted.
- ch1 sends a 70-word packet with `DEPTH = 64`. Expect 64 words stored, `b_last_o` on word 64, `ovf_o` pulse, words 65–70 accepted and discarded, 64 drain pulses, then IDLE.
- Length-1 packet from ch0 while ch1 is waiting. Expect `pkt_len_o = 1`, and ch1's first beat exactly 2 cycles after the single drain pulse.
- Random `sG_valid_i` gaps and `b_ready_i` stalls over 5 packets. Expect no lost or duplicated words, and the drain-pulse count per packet equal to `pkt_len_o`.
- Assert `rst_n` low mid-FILL after 10 words. Expect all outputs at reset values immediately, and ch0 to win the next tie after release.

Source files
------------

// File: rtl/softmax_buf_pkg.sv
// Shared definitions for the softmax accelerator buffer front end.
// Holds the scheduler state encoding, the default buffer depth and the
// data word width, plus the 2-way round-robin pick rule.
package softmax_buf_pkg;

    localparam int DEPTH_DEF = 64;
    localparam int DATA_W    = 32;

    // Scheduler state encoding.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_DROP  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    // Round-robin pick between two requesters: on a tie the one that was
    // not granted last wins, otherwise whichever is valid. Returns 0 when
    // neither is valid (the caller qualifies with the OR of the valids).
    function automatic logic rr2_pick(input logic v0, input logic v1, input logic last_grant);
        logic idx;
        if (v0 && v1) begin
            idx = ~last_grant;
        end else if (v1) begin
            idx = 1'b1;
        end else begin
            idx = 1'b0;
        end
        return idx;
    endfunction

endpackage

// File: rtl/buffer_pkt_arbiter_rr2_picker.sv
// rr2_picker: combinational 2-way round-robin pick.
// Ports:
//   v0_i, v1_i       requester valids
//   last_grant_i     index granted on the previous grant
//   gnt_valid_o      at least one requester is valid
//   gnt_idx_o        index of the requester to grant
module rr2_picker
    import softmax_buf_pkg::*;
(
    input  logic v0_i,
    input  logic v1_i,
    input  logic last_grant_i,
    output logic gnt_valid_o,
    output logic gnt_idx_o
);

    // Pick the winner from the two valids and the previous grant.
    always_comb begin
        gnt_valid_o = v0_i | v1_i;
        gnt_idx_o   = rr2_pick(v0_i, v1_i, last_grant_i);
    end

endmodule

// File: rtl/buffer_pkt_arbiter.sv
// buffer_pkt_arbiter: packet-level round-robin scheduler sharing a single
// collect/drain buffer between two requesters. A granted packet owns the
// buffer until its last beat is accepted and every stored word has been
// drained. Packets longer than DEPTH are cut at DEPTH words (the stored
// copy gets last on word DEPTH) and the remaining beats are swallowed.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   sN_valid_i/data_i/last_i   requester N beat (N = 0, 1)
//   sN_ready_o                 requester N beat accepted
//   b_valid_o/data_o/last_o    beat toward the buffer write side
//   b_ready_i                  buffer can accept a beat
//   b_drain_i                  one pulse per word leaving the buffer
//   m_chan_o                   owner of the buffered packet
//   pkt_len_o                  words stored for the current packet
//   busy_o                     scheduler not idle
//   ovf_o                      one-cycle pulse when a packet is truncated
module buffer_pkt_arbiter
    import softmax_buf_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int LEN_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s0_valid_i,
    input  logic [DATA_W-1:0] s0_data_i,
    input  logic              s0_last_i,
    output logic              s0_ready_o,
    input  logic              s1_valid_i,
    input  logic [DATA_W-1:0] s1_data_i,
    input  logic              s1_last_i,
    output logic              s1_ready_o,
    output logic              b_valid_o,
    output logic [DATA_W-1:0] b_data_o,
    output logic              b_last_o,
    input  logic              b_ready_i,
    input  logic              b_drain_i,
    output logic              m_chan_o,
    output logic [LEN_W-1:0]  pkt_len_o,
    output logic              busy_o,
    output logic              ovf_o
);

    localparam logic [LEN_W-1:0] FILL_LAST = LEN_W'(DEPTH - 1);
    localparam logic [LEN_W-1:0] LEN_FULL  = LEN_W'(DEPTH);

    logic [1:0]       state_q,      state_d;
    logic             chan_q,       chan_d;
    logic             last_grant_q, last_grant_d;
    logic [LEN_W-1:0] fill_cnt_q,   fill_cnt_d;
    logic [LEN_W-1:0] drain_cnt_q,  drain_cnt_d;
    logic [LEN_W-1:0] pkt_len_q,    pkt_len_d;
    logic             ovf_q,        ovf_d;

    logic              gnt_valid_s;
    logic              gnt_idx_s;
    logic              g_valid_s;
    logic [DATA_W-1:0] g_data_s;
    logic              g_last_s;
    logic              g_ready_s;
    logic              hs_s;
    logic              in_fill_s;
    logic              in_drop_s;
    logic              fill_at_max_s;
    logic [LEN_W-1:0]  drain_next_s;
    logic              drain_done_s;

    rr2_picker u_picker (
        .v0_i         (s0_valid_i),
        .v1_i         (s1_valid_i),
        .last_grant_i (last_grant_q),
        .gnt_valid_o  (gnt_valid_s),
        .gnt_idx_o    (gnt_idx_s)
    );

    // Owner-side mux, ready steering and the pass-through path to the buffer.
    always_comb begin
        in_fill_s     = (state_q == ST_FILL);
        in_drop_s     = (state_q == ST_DROP);
        g_valid_s     = chan_q ? s1_valid_i : s0_valid_i;
        g_data_s      = chan_q ? s1_data_i  : s0_data_i;
        g_last_s      = chan_q ? s1_last_i  : s0_last_i;
        fill_at_max_s = (fill_cnt_q == FILL_LAST);
        // DROP accepts unconditionally so the truncated tail cannot block.
        if (in_fill_s) begin
            g_ready_s = b_ready_i;
        end else if (in_drop_s) begin
            g_ready_s = 1'b1;
        end else begin
            g_ready_s = 1'b0;
        end
        hs_s       = g_valid_s & g_ready_s;
        s0_ready_o = g_ready_s & ~chan_q;
        s1_ready_o = g_ready_s &  chan_q;
        b_valid_o  = in_fill_s & g_valid_s;
        b_data_o   = in_fill_s ? g_data_s : {DATA_W{1'b0}};
        b_last_o   = in_fill_s & (g_last_s | fill_at_max_s);
        // Drain pulses only count once the packet owns the drain side.
        drain_next_s = drain_cnt_q
                     + LEN_W'(b_drain_i & (in_drop_s | (state_q == ST_DRAIN)));
        drain_done_s = (drain_next_s == pkt_len_q);
        busy_o       = (state_q != ST_IDLE);
        m_chan_o     = chan_q;
        pkt_len_o    = pkt_len_q;
        ovf_o        = ovf_q;
    end

    // Next-state logic for the packet scheduler and its counters.
    always_comb begin
        state_d      = state_q;
        chan_d       = chan_q;
        last_grant_d = last_grant_q;
        fill_cnt_d   = fill_cnt_q;
        drain_cnt_d  = drain_next_s;
        pkt_len_d    = pkt_len_q;
        ovf_d        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (gnt_valid_s) begin
                    chan_d       = gnt_idx_s;
                    last_grant_d = gnt_idx_s;
                    fill_cnt_d   = {LEN_W{1'b0}};
                    drain_cnt_d  = {LEN_W{1'b0}};
                    state_d      = ST_FILL;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (hs_s) begin
                    fill_cnt_d = fill_cnt_q + LEN_W'(1'b1);
                    if (g_last_s) begin
                        pkt_len_d = fill_cnt_q + LEN_W'(1'b1);
                        state_d   = ST_DRAIN;
                    end else if (fill_at_max_s) begin
                        pkt_len_d = LEN_FULL;
                        ovf_d     = 1'b1;
                        state_d   = ST_DROP;
                    end else begin
                        state_d = ST_FILL;
                    end
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_DROP: begin
                // The buffer may already be empty when the tail finishes.
                if (hs_s && g_last_s) begin
                    state_d = drain_done_s ? ST_IDLE : ST_DRAIN;
                end else begin
                    state_d = ST_DROP;
                end
            end
            ST_DRAIN: begin
                if (drain_done_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Scheduler state registers; last_grant resets to 1 so ch0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            chan_q       <= 1'b0;
            last_grant_q <= 1'b1;
            fill_cnt_q   <= {LEN_W{1'b0}};
            drain_cnt_q  <= {LEN_W{1'b0}};
            pkt_len_q    <= {LEN_W{1'b0}};
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            chan_q       <= chan_d;
            last_grant_q <= last_grant_d;
            fill_cnt_q   <= fill_cnt_d;
            drain_cnt_q  <= drain_cnt_d;
            pkt_len_q    <= pkt_len_d;
            ovf_q        <= ovf_d;
        end
    end

endmodule

// File: tb/tb_buffer_pkt_arbiter.sv
// Self-checking bench for buffer_pkt_arbiter (DEPTH = 64).
module tb_buffer_pkt_arbiter;

    localparam int   DEPTH = 64;
    localparam int   LEN_W = 7;
    localparam bit   H = 1'b1;
    localparam bit   L = 1'b0;
    localparam logic [31:0] Z = 32'h0;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             s0_valid_i = 1'b0, s0_last_i = 1'b0, s1_valid_i = 1'b0, s1_last_i = 1'b0;
    logic [31:0]      s0_data_i = 32'h0, s1_data_i = 32'h0;
    logic             s0_ready_o, s1_ready_o;
    logic             b_valid_o, b_last_o;
    logic [31:0]      b_data_o;
    logic             b_ready_i = 1'b0, b_drain_i = 1'b0;
    logic             m_chan_o, busy_o, ovf_o;
    logic [LEN_W-1:0] pkt_len_o;

    int n_chk  = 0;
    int n_fail = 0;

    buffer_pkt_arbiter #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .s0_valid_i(s0_valid_i), .s0_data_i(s0_data_i), .s0_last_i(s0_last_i), .s0_ready_o(s0_ready_o),
        .s1_valid_i(s1_valid_i), .s1_data_i(s1_data_i), .s1_last_i(s1_last_i), .s1_ready_o(s1_ready_o),
        .b_valid_o(b_valid_o), .b_data_o(b_data_o), .b_last_o(b_last_o), .b_ready_i(b_ready_i),
        .b_drain_i(b_drain_i), .m_chan_o(m_chan_o), .pkt_len_o(pkt_len_o),
        .busy_o(busy_o), .ovf_o(ovf_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit r; bit s0v; logic [31:0] s0d; bit s0l; bit s1v; logic [31:0] s1d; bit s1l; bit br; bit bd;
        bit e0; bit e1; bit ebv; logic [31:0] ebd; bit ebl; bit ech; logic [LEN_W-1:0] elen; bit ebsy;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [63:0] outs();
        return {18'b0, s0_ready_o, s1_ready_o, b_valid_o, b_data_o, b_last_o,
                m_chan_o, pkt_len_o, busy_o, ovf_o};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input bit r, input bit s0v, input logic [31:0] s0d, input bit s0l,
                       input bit s1v, input logic [31:0] s1d, input bit s1l, input bit br, input bit bd,
                       input bit e0, input bit e1, input bit ebv, input logic [31:0] ebd, input bit ebl,
                       input bit ech, input logic [LEN_W-1:0] elen, input bit ebsy);
        vec_t v;
        v.r = r; v.s0v = s0v; v.s0d = s0d; v.s0l = s0l; v.s1v = s1v; v.s1d = s1d; v.s1l = s1l;
        v.br = br; v.bd = bd; v.e0 = e0; v.e1 = e1; v.ebv = ebv; v.ebd = ebd; v.ebl = ebl;
        v.ech = ech; v.elen = elen; v.ebsy = ebsy;
        vecs.push_back(v);
    endtask

    task automatic idle_inputs();
        s0_valid_i = 1'b0; s0_data_i = 32'h0; s0_last_i = 1'b0;
        s1_valid_i = 1'b0; s1_data_i = 32'h0; s1_last_i = 1'b0;
        b_ready_i = 1'b0; b_drain_i = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        idle_inputs();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // Drives one packet of n words from channel ch and acts as the buffer.
    task automatic run_pkt(input int ch, input int n, input logic [31:0] base, input bit rnd);
        int sent = 0, stored = 0, drained = 0, cyc = 0, hs_full = -10;
        int ovf_cnt = 0, ovf_bad = 0, data_err = 0, last_err = 0, xrdy_err = 0, len_err = 0, chan_err = 0;
        int exp_len;
        bit done_store = 1'b0, fin = 1'b0, sv, src_rdy, xr;
        exp_len = (n > DEPTH) ? DEPTH : n;
        while (!fin && cyc < 4000) begin
            @(posedge clk); #1;
            sv = (sent < n) && (!rnd || $urandom_range(0, 3) != 0);
            if (ch == 0) begin
                s0_valid_i = sv; s0_data_i = base + 32'(sent); s0_last_i = (sent == n - 1);
                s1_valid_i = 1'b0;
            end else begin
                s1_valid_i = sv; s1_data_i = base + 32'(sent); s1_last_i = (sent == n - 1);
                s0_valid_i = 1'b0;
            end
            b_ready_i = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            b_drain_i = done_store && (drained < stored) && (!rnd || $urandom_range(0, 1) == 1);
            @(negedge clk);
            src_rdy = (ch == 0) ? s0_ready_o : s1_ready_o;
            xr      = (ch == 0) ? s1_ready_o : s0_ready_o;
            if (xr) xrdy_err++;
            if (done_store) begin
                if (pkt_len_o !== LEN_W'(exp_len)) len_err++;
                if (m_chan_o !== ch[0]) chan_err++;
            end
            if (b_valid_o && b_ready_i) begin
                if (b_data_o !== base + 32'(stored)) data_err++;
                stored++;
                if (b_last_o !== ((stored == n) || (stored == DEPTH))) last_err++;
                if (stored == exp_len) begin
                    done_store = 1'b1;
                    if (n > DEPTH) hs_full = cyc;
                end
            end
            if (ovf_o) begin
                ovf_cnt++;
                if (cyc != hs_full + 1) ovf_bad++;
            end
            if (sv && src_rdy) sent++;
            if (b_drain_i) drained++;
            if (done_store && drained == stored && sent == n) fin = 1'b1;
            cyc++;
        end
        if (!fin) chk("pkt_timeout", 64'(0), 64'(1));
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        chk("turnaround_idle", 64'(busy_o), 64'(0));
        chk("words_stored", 64'(stored), 64'(exp_len));
        chk("words_sent", 64'(sent), 64'(n));
        chk("data_order", 64'(data_err), 64'(0));
        chk("b_last_pos", 64'(last_err), 64'(0));
        chk("ovf_count", 64'(ovf_cnt), 64'(n > DEPTH ? 1 : 0));
        chk("ovf_timing", 64'(ovf_bad), 64'(0));
        chk("pkt_len", 64'(len_err), 64'(0));
        chk("m_chan", 64'(chan_err), 64'(0));
        chk("other_ready", 64'(xrdy_err), 64'(0));
    endtask

    initial begin
        int sent;
        // Single-channel 3-word packet with a stall and a FILL-time drain pulse.
        add(H, L,Z,L, L,Z,L, L,L, L,L,L,Z,L,L,7'd0,L);
        add(L, H,32'hA,L, L,Z,L, H,L, L,L,L,Z,L,L,7'd0,L);
        add(L, H,32'hA,L, L,Z,L, H,H, H,L,H,32'hA,L,L,7'd0,H);
        add(L, H,32'hB,L, L,Z,L, L,L, L,L,H,32'hB,L,L,7'd0,H);
        add(L, H,32'hB,L, L,Z,L, H,L, H,L,H,32'hB,L,L,7'd0,H);
        add(L, H,32'hC,H, L,Z,L, H,L, H,L,H,32'hC,H,L,7'd0,H);
        add(L, L,Z,L, L,Z,L, H,H, L,L,L,Z,L,L,7'd3,H);
        add(L, L,Z,L, L,Z,L, H,H, L,L,L,Z,L,L,7'd3,H);
        add(L, L,Z,L, L,Z,L, H,H, L,L,L,Z,L,L,7'd3,H);
        add(L, L,Z,L, L,Z,L, H,L, L,L,L,Z,L,L,7'd3,L);
        // Both channels continuously valid, 2-word packets: ch0, ch1, ch0, ch1.
        add(H, L,Z,L, L,Z,L, L,L, L,L,L,Z,L,L,7'd0,L);
        add(L, H,32'h10,L, H,32'h20,L, H,L, L,L,L,Z,L,L,7'd0,L);
        add(L, H,32'h10,L, H,32'h20,L, H,L, H,L,H,32'h10,L,L,7'd0,H);
        add(L, H,32'h11,H, H,32'h20,L, H,L, H,L,H,32'h11,H,L,7'd0,H);
        add(L, H,32'h12,L, H,32'h20,L, H,H, L,L,L,Z,L,L,7'd2,H);
        add(L, H,32'h12,L, H,32'h20,L, H,H, L,L,L,Z,L,L,7'd2,H);
        add(L, H,32'h12,L, H,32'h20,L, H,L, L,L,L,Z,L,L,7'd2,L);
        add(L, H,32'h12,L, H,32'h20,L, H,L, L,H,H,32'h20,L,H,7'd2,H);
        add(L, H,32'h12,L, H,32'h21,H, H,L, L,H,H,32'h21,H,H,7'd2,H);
        add(L, H,32'h12,L, H,32'h22,L, H,H, L,L,L,Z,L,H,7'd2,H);
        add(L, H,32'h12,L, H,32'h22,L, H,H, L,L,L,Z,L,H,7'd2,H);
        add(L, H,32'h12,L, H,32'h22,L, H,L, L,L,L,Z,L,H,7'd2,L);
        add(L, H,32'h12,L, H,32'h22,L, H,L, H,L,H,32'h12,L,L,7'd2,H);
        add(L, H,32'h13,H, H,32'h22,L, H,L, H,L,H,32'h13,H,L,7'd2,H);
        add(L, H,32'h14,L, H,32'h22,L, H,H, L,L,L,Z,L,L,7'd2,H);
        add(L, H,32'h14,L, H,32'h22,L, H,H, L,L,L,Z,L,L,7'd2,H);
        add(L, H,32'h14,L, H,32'h22,L, H,L, L,L,L,Z,L,L,7'd2,L);
        add(L, H,32'h14,L, H,32'h22,L, H,L, L,H,H,32'h22,L,H,7'd2,H);
        // Length-1 packet from ch0 with ch1 waiting; ch1 beat 2 cycles after the drain.
        add(H, L,Z,L, L,Z,L, L,L, L,L,L,Z,L,L,7'd0,L);
        add(L, H,32'h55,H, H,32'h66,L, H,L, L,L,L,Z,L,L,7'd0,L);
        add(L, H,32'h55,H, H,32'h66,L, H,L, H,L,H,32'h55,H,L,7'd0,H);
        add(L, L,Z,L, H,32'h66,L, H,L, L,L,L,Z,L,L,7'd1,H);
        add(L, L,Z,L, H,32'h66,L, H,H, L,L,L,Z,L,L,7'd1,H);
        add(L, L,Z,L, H,32'h66,L, H,L, L,L,L,Z,L,L,7'd1,L);
        add(L, L,Z,L, H,32'h66,L, H,L, L,H,H,32'h66,L,H,7'd1,H);

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk); #1;
            rst_n = ~vecs[i].r;
            s0_valid_i = vecs[i].s0v; s0_data_i = vecs[i].s0d; s0_last_i = vecs[i].s0l;
            s1_valid_i = vecs[i].s1v; s1_data_i = vecs[i].s1d; s1_last_i = vecs[i].s1l;
            b_ready_i = vecs[i].br; b_drain_i = vecs[i].bd;
            @(negedge clk);
            chk($sformatf("vec%0d", i), outs(),
                {18'b0, vecs[i].e0, vecs[i].e1, vecs[i].ebv, vecs[i].ebd, vecs[i].ebl,
                 vecs[i].ech, vecs[i].elen, vecs[i].ebsy, 1'b0});
        end

        // 70-word packet on ch1: truncation at 64, tail dropped while draining.
        do_reset();
        run_pkt(1, 70, 32'h1000, 1'b0);

        // Random valid gaps and buffer stalls over five packets.
        for (int p = 0; p < 5; p++) begin
            run_pkt(p % 2, $urandom_range(1, 12), 32'h5000 + 32'(p) * 32'h100, 1'b1);
        end

        // Reset mid-FILL after 10 words, then a tie must go to ch0.
        do_reset();
        sent = 0;
        for (int c = 0; c < 50 && sent < 10; c++) begin
            @(posedge clk); #1;
            s0_valid_i = 1'b1; s0_data_i = 32'h3000 + 32'(sent); s0_last_i = 1'b0;
            b_ready_i = 1'b1;
            @(negedge clk);
            if (s0_ready_o) sent++;
        end
        chk("mid_fill_words", 64'(sent), 64'(10));
        s1_valid_i = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("reset_mid_fill", outs(), 64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", 64'(busy_o), 64'(0));
        @(posedge clk); #1;
        @(negedge clk);
        chk("tie_after_reset", {61'b0, s0_ready_o, s1_ready_o, m_chan_o}, 64'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
